// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: CPU-side initiator for the UART controller's req/ack data
// interface. A four-register map on a single-cycle peripheral bus feeds a TX
// FIFO and drains an RX FIFO; two independent four-phase handshake engines
// move bytes between the FIFOs and the controller.
//
// TX engine states
//   state  | meaning
//   T_IDLE | no transfer outstanding; launch one when enabled and TX has data
//   T_REQ  | tx_data_req high, tx_data held, waiting for ack=1
//   T_REL  | req dropped, waiting for ack=0 before the next transfer
//
// RX engine states
//   state  | meaning
//   R_IDLE | no transfer outstanding; launch one when enabled and RX has room
//   R_REQ  | rx_data_req high, waiting for ack=1 to capture rx_data
//   R_REL  | req dropped, waiting for ack=0 before the next transfer
module uart_bus_bridge #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       en,
    output logic       rx_data_req,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ack,
    output logic       tx_data_req,
    output logic [7:0] tx_data,
    input  logic       tx_data_ack
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_REQ  = 2'd1;
    localparam logic [1:0] T_REL  = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_REL  = 2'd2;

    // control register and sticky overflow flag
    logic rx_ie;
    logic tx_ie;
    logic tx_drop;

    // FIFO storage and bookkeeping
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [AW:0]   tx_count;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [AW:0]   rx_count;

    logic [1:0] tx_state;
    logic [1:0] rx_state;

    // bus decode and FIFO flags, all from pre-edge state
    logic data_wr;
    logic data_rd;
    logic status_wr;
    logic ctrl_wr;
    logic tx_full;
    logic tx_empty;
    logic rx_valid;
    logic rx_full;
    logic tx_push;
    logic tx_pop;
    logic rx_push;
    logic rx_pop;

    // decode strobes and derive FIFO push/pop qualifiers
    always_comb begin
        data_wr   = wr && (addr == ADDR_DATA);
        data_rd   = rd && (addr == ADDR_DATA);
        status_wr = wr && (addr == ADDR_STATUS);
        ctrl_wr   = wr && (addr == ADDR_CTRL);

        tx_full   = (tx_count == FULL_CNT);
        tx_empty  = (tx_count == '0);
        rx_valid  = (rx_count != '0);
        rx_full   = (rx_count == FULL_CNT);

        // the full check deliberately ignores a same-edge engine pop
        tx_push   = data_wr && !tx_full;
        tx_pop    = (tx_state == T_REQ) && tx_data_ack;
        // room was guaranteed when the request was issued, so no full check
        rx_push   = (rx_state == R_REQ) && rx_data_ack;
        rx_pop    = data_rd && rx_valid;
    end

    // level interrupt from registered state only
    assign irq = (rx_ie && rx_valid) || (tx_ie && tx_empty);

    // TX FIFO storage (no reset needed; contents are qualified by the count)
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= wdata;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // CTRL register and sticky TX overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en      <= 1'b0;
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en    <= wdata[0];
                rx_ie <= wdata[1];
                tx_ie <= wdata[2];
            end
            if (status_wr) begin
                tx_drop <= 1'b0;
            end else if (data_wr && tx_full) begin
                tx_drop <= 1'b1;
            end
        end
    end

    // registered read data; holds its value between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (rd) begin
            case (addr)
                ADDR_DATA:   rdata <= rx_valid ? rx_mem[rx_rptr] : 8'h00;
                ADDR_STATUS: rdata <= {4'b0000, tx_drop, tx_full, tx_empty, rx_valid};
                ADDR_CTRL:   rdata <= {5'b00000, tx_ie, rx_ie, en};
                default:     rdata <= 8'h00;
            endcase
        end
    end

    // TX handshake engine; en only gates the launch of a new transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= T_IDLE;
            tx_data_req <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (en && !tx_empty) begin
                        tx_data     <= tx_mem[tx_rptr];
                        tx_data_req <= 1'b1;
                        tx_state    <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (tx_data_ack) begin
                        tx_data_req <= 1'b0;
                        tx_state    <= T_REL;
                    end
                end
                T_REL: begin
                    if (!tx_data_ack) begin
                        tx_state <= T_IDLE;
                    end
                end
                default: begin
                    tx_data_req <= 1'b0;
                    tx_state    <= T_IDLE;
                end
            endcase
        end
    end

    // RX handshake engine; a request is only raised while a slot is free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state    <= R_IDLE;
            rx_data_req <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (en && !rx_full) begin
                        rx_data_req <= 1'b1;
                        rx_state    <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (rx_data_ack) begin
                        rx_data_req <= 1'b0;
                        rx_state    <= R_REL;
                    end
                end
                R_REL: begin
                    if (!rx_data_ack) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: begin
                    rx_data_req <= 1'b0;
                    rx_state    <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: a queue-based reference model of the
// register map and FIFOs, behavioural controller responders on both
// handshakes, a table of register vectors and directed corner sequences,
// then a randomized bus/handshake mix.
module tb_uart_bus_bridge;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;
    logic       en;
    logic       rx_data_req;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ack = 1'b0;
    logic       tx_data_req;
    logic [7:0] tx_data;
    logic       tx_data_ack = 1'b0;

    always #5 clk = ~clk;

    uart_bus_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd          (rd),
        .wr          (wr),
        .wdata       (wdata),
        .rdata       (rdata),
        .irq         (irq),
        .en          (en),
        .rx_data_req (rx_data_req),
        .rx_data     (rx_data),
        .rx_data_ack (rx_data_ack),
        .tx_data_req (tx_data_req),
        .tx_data     (tx_data),
        .tx_data_ack (tx_data_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [7:0] tx_sent[$];
    logic       m_drop = 1'b0;
    logic [2:0] m_ctrl = 3'b000;
    logic [7:0] exp_rdata = 8'h00;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    // model step at negedge: checks current outputs, predicts the next edge
    always @(negedge clk) begin : model
        logic [7:0] st;
        bit         acc;
        if (!rst) begin
            m_tx.delete();
            m_rx.delete();
            m_drop    = 1'b0;
            m_ctrl    = 3'b000;
            hold_v    = 1'b0;
            exp_rdata = 8'h00;
        end else begin
            st = {4'b0000, m_drop, (m_tx.size() == DEPTH), (m_tx.size() == 0), (m_rx.size() != 0)};
            chk("irq", 8'(irq), 8'((m_ctrl[1] && m_rx.size() != 0) || (m_ctrl[2] && m_tx.size() == 0)));
            chk("en", 8'(en), 8'(m_ctrl[0]));
            chk("rx_req_without_room", 8'(rx_data_req && m_rx.size() >= DEPTH), 8'h00);
            chk("tx_req_without_data", 8'(tx_data_req && m_tx.size() == 0), 8'h00);
            if (!tx_data_req) begin
                hold_v = 1'b0;
            end else if (hold_v) begin
                chk("tx_data_stable", tx_data, hold_d);
            end else begin
                hold_v = 1'b1;
                hold_d = tx_data;
            end
            if (rd) begin
                case (addr)
                    2'd0:    exp_rdata = (m_rx.size() != 0) ? m_rx[0] : 8'h00;
                    2'd1:    exp_rdata = st;
                    2'd2:    exp_rdata = {5'b00000, m_ctrl};
                    default: exp_rdata = 8'h00;
                endcase
            end
            acc = (m_tx.size() < DEPTH);
            if (tx_data_req && tx_data_ack) begin
                chk("tx_pop_nonempty", 8'(m_tx.size() != 0), 8'h01);
                if (m_tx.size() != 0) begin
                    chk("tx_data_head", tx_data, m_tx[0]);
                    void'(m_tx.pop_front());
                end
                tx_sent.push_back(tx_data);
                hold_v = 1'b0;
            end
            if (wr && addr == 2'd0) begin
                if (acc) m_tx.push_back(wdata);
                else     m_drop = 1'b1;
            end
            if (wr && addr == 2'd1) m_drop = 1'b0;
            if (wr && addr == 2'd2) m_ctrl = wdata[2:0];
            if (rd && addr == 2'd0 && m_rx.size() != 0) void'(m_rx.pop_front());
            if (rx_data_req && rx_data_ack) m_rx.push_back(rx_data);
        end
    end

    // TX side of the controller: ack after tx_dly cycles, release after req drops
    int tx_dly = 2;
    int tx_wait = 0;
    bit tx_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            tx_data_ack = 1'b0;
            tx_wait = 0;
        end else if (tx_data_req && !tx_data_ack) begin
            if (tx_wait >= tx_dly) tx_data_ack = 1'b1;
            else tx_wait++;
        end else if (!tx_data_req && tx_data_ack) begin
            tx_data_ack = 1'b0;
            tx_wait = 0;
            if (tx_rand) tx_dly = $urandom_range(0, 3);
        end
    end

    // RX side of the controller: supplies rx_src bytes first, then random ones
    int         rx_dly = 1;
    int         rx_wait = 0;
    bit         rx_rand = 1'b0;
    bit         rx_on = 1'b0;
    logic [7:0] rx_src[$];
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            rx_data_ack = 1'b0;
            rx_wait = 0;
        end else if (rx_data_req && !rx_data_ack && rx_on) begin
            if (rx_wait >= rx_dly) begin
                rx_data = (rx_src.size() != 0) ? rx_src.pop_front() : 8'($urandom);
                rx_data_ack = 1'b1;
            end else begin
                rx_wait++;
            end
        end else if (!rx_data_req && rx_data_ack) begin
            rx_data_ack = 1'b0;
            rx_wait = 0;
            rx_data = 8'($urandom);
            if (rx_rand) rx_dly = $urandom_range(0, 3);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
        chk("rdata_model", rdata, exp_rdata);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        tx_rand = 1'b0;
        rx_rand = 1'b0;
        rx_on = 1'b0;
        tx_dly = 2;
        rx_dly = 1;
        rx_src.delete();
        tick(2);
        tx_sent.delete();
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic wait_tx_req(input string nm);
        int k = 0;
        while (!tx_data_req && k < 50) begin
            tick();
            k++;
        end
        chk(nm, 8'(tx_data_req), 8'h01);
    endtask

    task automatic wait_sent(input int n, input int budget, input string nm);
        int k = 0;
        while (tx_sent.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 8'(tx_sent.size() >= n), 8'h01);
    endtask

    task automatic wait_rx(input int n, input int budget, input string nm);
        int k = 0;
        while (m_rx.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 8'(m_rx.size() >= n), 8'h01);
    endtask

    typedef struct {
        bit         is_wr;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void vw(input logic [1:0] a, input logic [7:0] d);
        vecs.push_back('{1'b1, a, d, 8'h00});
    endfunction

    function automatic void vr(input logic [1:0] a, input logic [7:0] exp);
        vecs.push_back('{1'b0, a, 8'h00, exp});
    endfunction

    initial begin : watchdog
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] d;
        int r;

        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // reset values
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_en", 8'(en), 8'h00);
        chk("rst_rx_req", 8'(rx_data_req), 8'h00);
        chk("rst_tx_req", 8'(tx_data_req), 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);

        // reset asserted mid-TX handshake
        tx_dly = 50;
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'h99);
        wait_tx_req("midrst_req_up");
        #2 rst = 1'b0;
        #1;
        chk("midrst_rdata", rdata, 8'h00);
        chk("midrst_irq", 8'(irq), 8'h00);
        chk("midrst_en", 8'(en), 8'h00);
        chk("midrst_rx_req", 8'(rx_data_req), 8'h00);
        chk("midrst_tx_req", 8'(tx_data_req), 8'h00);
        chk("midrst_tx_data", tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tx_dly = 2;
        tick();
        bus_read(2'd1, d);
        chk("midrst_status", d, 8'h02);

        // register vectors: TX overflow with en=0, status clear, CTRL, reserved
        do_reset();
        vw(2'd2, 8'h00);
        for (int i = 0; i < 9; i++) vw(2'd0, 8'(i));
        vr(2'd1, 8'h0C);
        vw(2'd1, 8'h00);
        vr(2'd1, 8'h04);
        vr(2'd0, 8'h00);
        vr(2'd1, 8'h04);
        vw(2'd2, 8'h06);
        vr(2'd2, 8'h06);
        vw(2'd2, 8'hFE);
        vr(2'd2, 8'h06);
        vw(2'd3, 8'hFF);
        vr(2'd3, 8'h00);
        vr(2'd2, 8'h06);
        vw(2'd2, 8'h00);
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].a, vecs[i].d);
            end else begin
                bus_read(vecs[i].a, d);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            end
        end
        bus_write(2'd2, 8'h01);
        wait_sent(8, 300, "ovf_drain");
        tick(20);
        chk("ovf_sent_count", 8'(tx_sent.size()), 8'd8);
        for (int i = 0; i < 8 && i < tx_sent.size(); i++) chk($sformatf("ovf_byte%0d", i), tx_sent[i], 8'(i));
        bus_read(2'd1, d);
        chk("ovf_status_end", d, 8'h02);

        // TX ordering and start latency
        do_reset();
        tx_dly = 3;
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'h41);
        chk("tx_start_not_yet", 8'(tx_data_req), 8'h00);
        bus_write(2'd0, 8'h42);
        chk("tx_start_2edges", 8'(tx_data_req), 8'h01);
        chk("tx_start_data", tx_data, 8'h41);
        bus_write(2'd0, 8'h43);
        wait_sent(3, 100, "txord_done");
        tick(5);
        chk("txord_count", 8'(tx_sent.size()), 8'd3);
        for (int i = 0; i < 3 && i < tx_sent.size(); i++) chk($sformatf("txord_byte%0d", i), tx_sent[i], 8'(8'h41 + i));
        bus_read(2'd1, d);
        chk("txord_status", d, 8'h02);

        // RX fill to depth, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) rx_src.push_back(8'(8'h10 + i));
        rx_on = 1'b1;
        bus_write(2'd2, 8'h01);
        wait_rx(8, 200, "rxfill_full");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rxfill_req_low", 8'(rx_data_req), 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, d);
            chk($sformatf("rxfill_byte%0d", i), d, 8'(8'h10 + i));
        end
        wait_rx(1, 50, "rxfill_ninth");
        bus_read(2'd0, d);
        chk("rxfill_byte8", d, 8'h18);

        // empty read and irq sources
        do_reset();
        bus_read(2'd0, d);
        chk("empty_read", d, 8'h00);
        bus_read(2'd1, d);
        chk("empty_status", d, 8'h02);
        bus_write(2'd2, 8'h07);
        chk("irq_tx_empty", 8'(irq), 8'h01);
        bus_write(2'd2, 8'h03);
        chk("irq_rx_empty", 8'(irq), 8'h00);
        rx_src.push_back(8'h55);
        rx_dly = 0;
        rx_on = 1'b1;
        for (int k = 0; k < 20 && m_rx.size() == 0; k++) begin
            chk("irq_before_push", 8'(irq), 8'h00);
            tick();
        end
        chk("irq_rx_pushed", 8'(m_rx.size() != 0), 8'h01);
        chk("irq_after_push", 8'(irq), 8'h01);

        // disable mid-transfer
        do_reset();
        tx_dly = 4;
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'hA0);
        bus_write(2'd0, 8'hA1);
        bus_write(2'd0, 8'hA2);
        wait_tx_req("dis_req_up");
        bus_write(2'd2, 8'h00);
        wait_sent(1, 50, "dis_complete");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("dis_no_new_req", 8'(tx_data_req), 8'h00);
        end
        chk("dis_sent_count", 8'(tx_sent.size()), 8'd1);
        if (tx_sent.size() != 0) chk("dis_sent_byte", tx_sent[0], 8'hA0);
        bus_read(2'd1, d);
        chk("dis_status", d, 8'h00);

        // randomized bus traffic against randomized controller timing
        do_reset();
        tx_rand = 1'b1;
        rx_rand = 1'b1;
        rx_on = 1'b1;
        bus_write(2'd2, 8'h07);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      bus_write(2'd0, 8'($urandom));
            else if (r < 65) bus_read(2'd0, d);
            else if (r < 80) bus_read(2'd1, d);
            else if (r < 84) bus_write(2'd1, 8'($urandom));
            else if (r < 88) bus_write(2'd2, 8'($urandom) | 8'($urandom_range(0, 4) != 0));
            else if (r < 92) bus_read(2'(r), d);
            else             tick();
        end
        bus_write(2'd2, 8'h01);
        tick(100);
        bus_read(2'd1, d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
